// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Pops exe2mem entries, runs load/store requests against the data cache,
// aligns/extends load data and queues results in a small mem2wbk FIFO whose
// head drives writeback and the execute-stage memory bypass.
module mem_stage #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RES_RE,
  input  logic [31:0] MEM_DATA_RE,
  input  logic [5:0]  DEST_RE,
  input  logic [1:0]  MEM_SIZE_RE,
  input  logic        WB_RE,
  input  logic        MEM_SIGN_EXTEND_RE,
  input  logic        MEM_LOAD_RE,
  input  logic        MEM_STORE_RE,
  input  logic        EXCEPTION_RE,
  input  logic        EXE2MEM_EMPTY_SE,
  output logic        EXE2MEM_POP_SM,
  output logic [31:0] MCACHE_ADR_SM,
  output logic [31:0] MCACHE_DATA_SM,
  output logic [3:0]  MCACHE_BYTE_SEL_SM,
  output logic        MCACHE_LOAD_SM,
  output logic        MCACHE_STORE_SM,
  input  logic        MCACHE_ACK_SC,
  input  logic [31:0] MCACHE_RESULT_SC,
  input  logic        MEM2WBK_POP_SW,
  output logic        MEM2WBK_EMPTY_SM,
  output logic [31:0] MEM_RES_RM,
  output logic [5:0]  MEM_DEST_RM,
  output logic        MEM_WB_RM,
  output logic        MEM_EXCEPTION_RM
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  // Select the addressed lane of a cache word and extend it to 32 bits.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  lo,
                                             input logic [1:0]  size,
                                             input logic        sext);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word;
    r  = word;
    case (size)
      SZ_HALF: begin
        sh = word >> {lo[1], 4'b0000};
        r  = {{16{sext & sh[15]}}, sh[15:0]};
      end
      SZ_BYTE: begin
        sh = word >> {lo, 3'b000};
        r  = {{24{sext & sh[7]}}, sh[7:0]};
      end
      default: r = word;
    endcase
    return r;
  endfunction

  // Replicate store data across every lane it may land in.
  function automatic logic [31:0] lane_data(input logic [31:0] d,
                                            input logic [1:0]  size);
    case (size)
      SZ_HALF: return {2{d[15:0]}};
      SZ_BYTE: return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

  // Byte enables for a store; address bits below the lane size are ignored.
  function automatic logic [3:0] byte_sel(input logic [1:0] lo,
                                          input logic [1:0] size,
                                          input logic       store);
    logic [3:0] s;
    case (size)
      SZ_HALF: s = 4'b0011 << {lo[1], 1'b0};
      SZ_BYTE: s = 4'b0001 << lo;
      default: s = 4'b1111;
    endcase
    return store ? s : 4'b0000;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  state_t            state, state_nxt;
  logic              take, is_mem, busy;
  logic              pop_up, push;
  logic [31:0]       push_res;
  logic [5:0]        push_dest;
  logic              push_wb, push_exc;

  // Request registers captured at issue (p1 = cache request stage).
  logic [31:0]       req_addr_p1;
  logic [31:0]       req_data_p1;
  logic [3:0]        req_sel_p1;
  logic [1:0]        req_size_p1;
  logic              req_sign_p1;
  logic [5:0]        req_dest_p1;
  logic              req_wb_p1;
  logic              req_load_p1;

  // mem2wbk FIFO storage and control.
  logic [31:0]       fifo_res  [FIFO_DEPTH];
  logic [5:0]        fifo_dest [FIFO_DEPTH];
  logic              fifo_wb   [FIFO_DEPTH];
  logic              fifo_exc  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, fifo_pop;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign fifo_pop = MEM2WBK_POP_SW & ~empty;
  assign take     = ~EXE2MEM_EMPTY_SE & ~full;
  assign is_mem   = (MEM_LOAD_RE | MEM_STORE_RE) & ~EXCEPTION_RE;
  assign busy     = (state == WAIT_ACK);

  // FSM state register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state: issue memory ops, return to IDLE on cache ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (take && is_mem) state_nxt = WAIT_ACK;
      WAIT_ACK: if (MCACHE_ACK_SC)  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM outputs: upstream pop plus the FIFO push and its payload.
  always_comb begin
    pop_up    = 1'b0;
    push      = 1'b0;
    push_res  = RES_RE;
    push_dest = DEST_RE;
    push_wb   = 1'b0;
    push_exc  = 1'b0;
    case (state)
      IDLE: begin
        if (take) begin
          pop_up = 1'b1;
          if (!is_mem) begin
            push     = 1'b1;
            push_wb  = WB_RE & ~EXCEPTION_RE;
            push_exc = EXCEPTION_RE;
          end
        end
      end
      WAIT_ACK: begin
        if (MCACHE_ACK_SC) begin
          push      = 1'b1;
          push_dest = req_dest_p1;
          push_wb   = req_load_p1 & req_wb_p1;
          push_res  = req_load_p1 ?
                      align_load(MCACHE_RESULT_SC, req_addr_p1[1:0], req_size_p1, req_sign_p1) :
                      req_addr_p1;
        end
      end
      default: ;
    endcase
    if (reset) begin
      pop_up = 1'b0;
      push   = 1'b0;
    end
  end

  assign EXE2MEM_POP_SM = pop_up;

  // Stage p0 -> p1: latch the request when a memory op is issued.
  always_ff @(posedge clk) begin
    if (state == IDLE && take && is_mem) begin
      req_addr_p1 <= RES_RE;
      req_data_p1 <= lane_data(MEM_DATA_RE, MEM_SIZE_RE);
      req_sel_p1  <= byte_sel(RES_RE[1:0], MEM_SIZE_RE, MEM_STORE_RE);
      req_size_p1 <= MEM_SIZE_RE;
      req_sign_p1 <= MEM_SIGN_EXTEND_RE;
      req_dest_p1 <= DEST_RE;
      req_wb_p1   <= WB_RE;
      req_load_p1 <= MEM_LOAD_RE;
    end
  end

  // Cache request is live only while waiting for the ack.
  assign MCACHE_LOAD_SM     = busy & req_load_p1;
  assign MCACHE_STORE_SM    = busy & ~req_load_p1;
  assign MCACHE_ADR_SM      = busy ? {req_addr_p1[31:2], 2'b00} : 32'd0;
  assign MCACHE_DATA_SM     = busy ? req_data_p1 : 32'd0;
  assign MCACHE_BYTE_SEL_SM = busy ? req_sel_p1 : 4'b0000;

  // Stage p1 -> p2: FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= next_ptr(wr_ptr);
      if (fifo_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload write.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_res[wr_ptr]  <= push_res;
      fifo_dest[wr_ptr] <= push_dest;
      fifo_wb[wr_ptr]   <= push_wb;
      fifo_exc[wr_ptr]  <= push_exc;
    end
  end

  // Head outputs are zeroed when empty so the bypass never matches.
  assign MEM2WBK_EMPTY_SM = empty;
  assign MEM_RES_RM       = empty ? 32'd0 : fifo_res[rd_ptr];
  assign MEM_DEST_RM      = empty ? 6'd0  : fifo_dest[rd_ptr];
  assign MEM_WB_RM        = empty ? 1'b0  : fifo_wb[rd_ptr];
  assign MEM_EXCEPTION_RM = empty ? 1'b0  : fifo_exc[rd_ptr];

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, loads/stores with
// alignment, delayed ack, FIFO full back-pressure and reset mid-request.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [31:0] RES_RE, MEM_DATA_RE;
  logic [5:0]  DEST_RE;
  logic [1:0]  MEM_SIZE_RE;
  logic        WB_RE, MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, EXCEPTION_RE;
  logic        EXE2MEM_EMPTY_SE, EXE2MEM_POP_SM;
  logic [31:0] MCACHE_ADR_SM, MCACHE_DATA_SM;
  logic [3:0]  MCACHE_BYTE_SEL_SM;
  logic        MCACHE_LOAD_SM, MCACHE_STORE_SM, MCACHE_ACK_SC;
  logic [31:0] MCACHE_RESULT_SC;
  logic        MEM2WBK_POP_SW, MEM2WBK_EMPTY_SM;
  logic [31:0] MEM_RES_RM;
  logic [5:0]  MEM_DEST_RM;
  logic        MEM_WB_RM, MEM_EXCEPTION_RM;

  int vectors = 0;
  int miscompares = 0;

  mem_stage #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .RES_RE(RES_RE), .MEM_DATA_RE(MEM_DATA_RE), .DEST_RE(DEST_RE),
    .MEM_SIZE_RE(MEM_SIZE_RE), .WB_RE(WB_RE), .MEM_SIGN_EXTEND_RE(MEM_SIGN_EXTEND_RE),
    .MEM_LOAD_RE(MEM_LOAD_RE), .MEM_STORE_RE(MEM_STORE_RE), .EXCEPTION_RE(EXCEPTION_RE),
    .EXE2MEM_EMPTY_SE(EXE2MEM_EMPTY_SE), .EXE2MEM_POP_SM(EXE2MEM_POP_SM),
    .MCACHE_ADR_SM(MCACHE_ADR_SM), .MCACHE_DATA_SM(MCACHE_DATA_SM),
    .MCACHE_BYTE_SEL_SM(MCACHE_BYTE_SEL_SM), .MCACHE_LOAD_SM(MCACHE_LOAD_SM),
    .MCACHE_STORE_SM(MCACHE_STORE_SM), .MCACHE_ACK_SC(MCACHE_ACK_SC),
    .MCACHE_RESULT_SC(MCACHE_RESULT_SC), .MEM2WBK_POP_SW(MEM2WBK_POP_SW),
    .MEM2WBK_EMPTY_SM(MEM2WBK_EMPTY_SM), .MEM_RES_RM(MEM_RES_RM),
    .MEM_DEST_RM(MEM_DEST_RM), .MEM_WB_RM(MEM_WB_RM), .MEM_EXCEPTION_RM(MEM_EXCEPTION_RM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [31:0] res, input logic [5:0] dest, input logic [1:0] size,
                           input logic ld, input logic st, input logic sx, input logic [31:0] data);
    RES_RE = res; DEST_RE = dest; MEM_SIZE_RE = size; MEM_LOAD_RE = ld; MEM_STORE_RE = st;
    MEM_SIGN_EXTEND_RE = sx; MEM_DATA_RE = data; WB_RE = 1'b1; EXCEPTION_RE = 1'b0;
    EXE2MEM_EMPTY_SE = 1'b0;
  endtask

  task automatic pop_head();
    MEM2WBK_POP_SW = 1'b1;
    step();
    MEM2WBK_POP_SW = 1'b0;
  endtask

  // Load issued, acked the following cycle, result checked at FIFO head.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sx, input logic [31:0] word, input logic [31:0] exp);
    set_entry(addr, 6'd7, size, 1'b1, 1'b0, sx, 32'd0);
    #1 chk({tag, "_pop"}, EXE2MEM_POP_SM, 1);
    step();
    EXE2MEM_EMPTY_SE = 1'b1; MEM_LOAD_RE = 1'b0;
    #1 chk({tag, "_ld"}, MCACHE_LOAD_SM, 1);
    chk({tag, "_adr"}, MCACHE_ADR_SM, {addr[31:2], 2'b00});
    chk({tag, "_sel"}, MCACHE_BYTE_SEL_SM, 0);
    MCACHE_ACK_SC = 1'b1; MCACHE_RESULT_SC = word;
    step();
    MCACHE_ACK_SC = 1'b0;
    #1 chk({tag, "_ldoff"}, MCACHE_LOAD_SM, 0);
    chk({tag, "_res"}, MEM_RES_RM, exp);
    chk({tag, "_dest"}, MEM_DEST_RM, 7);
    chk({tag, "_wb"}, MEM_WB_RM, 1);
    pop_head();
  endtask

  // Store issued, request encoding checked, acked the following cycle.
  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] data, input logic [31:0] exp_data,
                          input logic [3:0] exp_sel);
    set_entry(addr, 6'd9, size, 1'b0, 1'b1, 1'b0, data);
    #1 chk({tag, "_pop"}, EXE2MEM_POP_SM, 1);
    step();
    EXE2MEM_EMPTY_SE = 1'b1; MEM_STORE_RE = 1'b0;
    #1 chk({tag, "_st"}, MCACHE_STORE_SM, 1);
    chk({tag, "_ld"}, MCACHE_LOAD_SM, 0);
    chk({tag, "_adr"}, MCACHE_ADR_SM, {addr[31:2], 2'b00});
    chk({tag, "_data"}, MCACHE_DATA_SM, exp_data);
    chk({tag, "_sel"}, MCACHE_BYTE_SEL_SM, exp_sel);
    MCACHE_ACK_SC = 1'b1; MCACHE_RESULT_SC = 32'hDEADBEEF;
    step();
    MCACHE_ACK_SC = 1'b0;
    #1 chk({tag, "_stoff"}, MCACHE_STORE_SM, 0);
    chk({tag, "_empty"}, MEM2WBK_EMPTY_SM, 0);
    chk({tag, "_res"}, MEM_RES_RM, addr);
    chk({tag, "_wb"}, MEM_WB_RM, 0);
    pop_head();
  endtask

  initial begin
    reset = 1'b1;
    RES_RE = '0; MEM_DATA_RE = '0; DEST_RE = '0; MEM_SIZE_RE = '0; WB_RE = 1'b0;
    MEM_SIGN_EXTEND_RE = 1'b0; MEM_LOAD_RE = 1'b0; MEM_STORE_RE = 1'b0; EXCEPTION_RE = 1'b0;
    EXE2MEM_EMPTY_SE = 1'b1; MCACHE_ACK_SC = 1'b0; MCACHE_RESULT_SC = '0; MEM2WBK_POP_SW = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_empty", MEM2WBK_EMPTY_SM, 1);
    chk("rst_dest", MEM_DEST_RM, 0);
    chk("rst_wb", MEM_WB_RM, 0);
    chk("rst_res", MEM_RES_RM, 0);
    chk("rst_ld", MCACHE_LOAD_SM, 0);
    chk("rst_st", MCACHE_STORE_SM, 0);
    chk("rst_adr", MCACHE_ADR_SM, 0);
    chk("rst_pop", EXE2MEM_POP_SM, 0);

    // ALU pass-through
    set_entry(32'h00001234, 6'd5, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 chk("alu_pop", EXE2MEM_POP_SM, 1);
    chk("alu_empty0", MEM2WBK_EMPTY_SM, 1);
    step();
    EXE2MEM_EMPTY_SE = 1'b1;
    #1 chk("alu_empty", MEM2WBK_EMPTY_SM, 0);
    chk("alu_res", MEM_RES_RM, 32'h00001234);
    chk("alu_dest", MEM_DEST_RM, 5);
    chk("alu_wb", MEM_WB_RM, 1);
    chk("alu_pop1", EXE2MEM_POP_SM, 0);
    pop_head();
    #1 chk("alu_drain", MEM2WBK_EMPTY_SM, 1);
    chk("alu_drain_dest", MEM_DEST_RM, 0);

    // Trapped load bypasses the cache
    set_entry(32'h00000444, 6'd6, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
    EXCEPTION_RE = 1'b1;
    #1 chk("exc_pop", EXE2MEM_POP_SM, 1);
    step();
    EXE2MEM_EMPTY_SE = 1'b1; EXCEPTION_RE = 1'b0; MEM_LOAD_RE = 1'b0;
    #1 chk("exc_ld", MCACHE_LOAD_SM, 0);
    chk("exc_flag", MEM_EXCEPTION_RM, 1);
    chk("exc_wb", MEM_WB_RM, 0);
    chk("exc_res", MEM_RES_RM, 32'h00000444);
    pop_head();

    // Loads with alignment and extension
    do_load("lb_s", 32'h00000103, 2'b10, 1'b1, 32'h80FFFF7F, 32'hFFFFFF80);
    do_load("lb_u", 32'h00000103, 2'b10, 1'b0, 32'h80FFFF7F, 32'h00000080);
    do_load("lh_s", 32'h00000102, 2'b01, 1'b1, 32'h80FFFF7F, 32'hFFFF80FF);
    do_load("lb0_s", 32'h00000100, 2'b10, 1'b1, 32'h80FFFF7F, 32'h0000007F);
    do_load("lw", 32'h00000104, 2'b00, 1'b1, 32'h80FFFF7F, 32'h80FFFF7F);

    // Stores
    do_store("sh", 32'h00000102, 2'b01, 32'h0000ABCD, 32'hABCDABCD, 4'b1100);
    do_store("sb", 32'h00000101, 2'b10, 32'h12345678, 32'h78787878, 4'b0010);
    do_store("sw", 32'h00000208, 2'b00, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111);

    // Delayed ack with a second entry waiting upstream
    set_entry(32'h00000200, 6'd3, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
    #1 chk("dly_pop", EXE2MEM_POP_SM, 1);
    step();
    set_entry(32'h0000BEEF, 6'd4, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        MCACHE_ACK_SC = 1'b1; MCACHE_RESULT_SC = 32'h11223344;
      end
      #1 chk("dly_ld", MCACHE_LOAD_SM, 1);
      chk("dly_adr", MCACHE_ADR_SM, 32'h00000200);
      chk("dly_pop0", EXE2MEM_POP_SM, 0);
      chk("dly_nopush", MEM2WBK_EMPTY_SM, 1);
      step();
    end
    MCACHE_ACK_SC = 1'b0;
    #1 chk("dly_ldoff", MCACHE_LOAD_SM, 0);
    chk("dly_res", MEM_RES_RM, 32'h11223344);
    chk("dly_pop2", EXE2MEM_POP_SM, 1);
    step();
    EXE2MEM_EMPTY_SE = 1'b1;
    #1 chk("dly_head", MEM_RES_RM, 32'h11223344);
    pop_head();
    #1 chk("dly_second", MEM_RES_RM, 32'h0000BEEF);
    chk("dly_second_dest", MEM_DEST_RM, 4);
    pop_head();
    #1 chk("dly_drain", MEM2WBK_EMPTY_SM, 1);

    // FIFO full back-pressure and ordering
    set_entry(32'h0000000A, 6'd10, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 chk("full_popA", EXE2MEM_POP_SM, 1);
    step();
    set_entry(32'h0000000B, 6'd11, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 chk("full_popB", EXE2MEM_POP_SM, 1);
    step();
    set_entry(32'h0000000C, 6'd12, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 chk("full_popC0", EXE2MEM_POP_SM, 0);
    step();
    #1 chk("full_popC1", EXE2MEM_POP_SM, 0);
    chk("full_headA", MEM_RES_RM, 32'h0000000A);
    MEM2WBK_POP_SW = 1'b1;
    #1 chk("full_nobypass", EXE2MEM_POP_SM, 0);
    step();
    MEM2WBK_POP_SW = 1'b0;
    #1 chk("full_popC2", EXE2MEM_POP_SM, 1);
    chk("full_headB", MEM_RES_RM, 32'h0000000B);
    step();
    EXE2MEM_EMPTY_SE = 1'b1;
    #1 chk("full_headB2", MEM_RES_RM, 32'h0000000B);
    pop_head();
    #1 chk("full_headC", MEM_RES_RM, 32'h0000000C);
    chk("full_destC", MEM_DEST_RM, 12);
    pop_head();
    #1 chk("full_drain", MEM2WBK_EMPTY_SM, 1);
    pop_head();
    #1 chk("empty_pop_ignored", MEM2WBK_EMPTY_SM, 1);

    // Reset during WAIT_ACK, ack on the reset cycle and the one after
    set_entry(32'h00000300, 6'd2, 2'b00, 1'b1, 1'b0, 1'b0, 32'd0);
    step();
    EXE2MEM_EMPTY_SE = 1'b1; MEM_LOAD_RE = 1'b0;
    #1 chk("rw_ld", MCACHE_LOAD_SM, 1);
    reset = 1'b1; MCACHE_ACK_SC = 1'b1; MCACHE_RESULT_SC = 32'h55555555;
    step();
    reset = 1'b0;
    #1 chk("rw_ldoff", MCACHE_LOAD_SM, 0);
    chk("rw_empty", MEM2WBK_EMPTY_SM, 1);
    chk("rw_pop", EXE2MEM_POP_SM, 0);
    step();
    MCACHE_ACK_SC = 1'b0;
    #1 chk("rw_stale", MEM2WBK_EMPTY_SM, 1);
    chk("rw_ldoff2", MCACHE_LOAD_SM, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Pops entries from the exe2mem FIFO and issues load/store requests to the data cache over a request/ack handshake.
- Aligns load data and sign- or zero-extends it.
- Pushes results into an internal mem2wbk FIFO whose head feeds writeback and the execute-stage memory bypass (MEM_DEST_RM/MEM_RES_RM).

Parameters:
FIFO_DEPTH, 2, number of entries in the mem2wbk FIFO (>=1).

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  synchronous, active-high reset
RES_RE  in  32  execute result; byte address for loads/stores
MEM_DATA_RE  in  32  store data
DEST_RE  in  6  destination register
MEM_SIZE_RE  in  2  00 word, 01 half, 10 byte
WB_RE  in  1  writeback enable
MEM_SIGN_EXTEND_RE  in  1  1 = sign-extend load data
MEM_LOAD_RE  in  1  load operation
MEM_STORE_RE  in  1  store operation
EXCEPTION_RE  in  1  entry already trapped; no memory access
EXE2MEM_EMPTY_SE  in  1  upstream FIFO empty
EXE2MEM_POP_SM  out  1  pop upstream FIFO
MCACHE_ADR_SM  out  32  word-aligned cache address
MCACHE_DATA_SM  out  32  store data, lane-replicated
MCACHE_BYTE_SEL_SM  out  4  store byte enables
MCACHE_LOAD_SM  out  1  load request
MCACHE_STORE_SM  out  1  store request
MCACHE_ACK_SC  in  1  cache completion, one-cycle pulse
MCACHE_RESULT_SC  in  32  load word; valid with ack
MEM2WBK_POP_SW  in  1  writeback pops head entry
MEM2WBK_EMPTY_SM  out  1  mem2wbk FIFO empty
MEM_RES_RM  out  32  head result
MEM_DEST_RM  out  6  head destination; forced 0 when empty
MEM_WB_RM  out  1  head writeback enable; forced 0 when empty
MEM_EXCEPTION_RM  out  1  head exception flag

Behaviour:
- Reset (synchronous, wins over everything):
  - FSM returns to IDLE and the FIFO is emptied.
  - All outputs read 0, except MEM2WBK_EMPTY_SM = 1.
  - An in-flight cache request is abandoned; an ack arriving after reset is ignored.
- FSM states:
  - IDLE: waiting for an upstream entry.
  - WAIT_ACK: cache request outstanding.
- IDLE, entry available (EXE2MEM_EMPTY_SE = 0) and FIFO not full:
  - Non-memory op or EXCEPTION_RE = 1:
    - EXE2MEM_POP_SM = 1 and push in the same cycle.
    - Pushed fields: RES_RE, DEST_RE, EXCEPTION_RE; wb = WB_RE & !EXCEPTION_RE.
    - FSM stays in IDLE.
  - Load or store (no exception):
    - EXE2MEM_POP_SM = 1.
    - Address, size, sign, dest, wb and data are latched into request registers.
    - FSM moves to WAIT_ACK.
- Request outputs:
  - Registered; asserted starting the cycle after issue.
  - Held stable until the ack cycle inclusive.
  - Deasserted the cycle after ack.
- Request encoding:
  - MCACHE_ADR_SM = {addr[31:2], 2'b00}.
  - Byte select: word 1111; half 0011<<addr[1:0]; byte 0001<<addr[1:0]; 0000 for loads.
  - Store data: word unchanged; half {2{d[15:0]}}; byte {4{d[7:0]}}.
- WAIT_ACK:
  - EXE2MEM_POP_SM = 0 and no push until MCACHE_ACK_SC = 1.
  - On ack, push and return to IDLE. The next entry may issue the cycle after return, giving minimum 2 cycles per memory op.
  - Load push: aligned data from MCACHE_RESULT_SC:
    - byte = word >> 8*addr[1:0], take [7:0];
    - half = word >> 16*addr[1], take [15:0];
    - extend per MEM_SIGN_EXTEND_RE.
  - Store push: res = address, wb = 0.
- Misaligned addresses are trapped upstream and never reach this block; low address bits outside the selected lane are ignored.
- mem2wbk FIFO:
  - FULL is evaluated before a same-cycle pop (no full-bypass). EMPTY deasserts the cycle after the first push.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the occupancy unchanged.
  - Data pushed while entering WAIT_ACK is impossible by construction. Space checked at issue is guaranteed at ack because only pops occur meanwhile.
- Head outputs:
  - Combinational from the FIFO head; no pipeline bubble between push and visibility beyond one register stage.
  - MEM_DEST_RM = 0 when empty so the execute bypass never matches.
- MEM2WBK_POP_SW while empty is ignored.

Test Plan:
1. ALU entry RES=0x00001234, DEST=5, WB=1 in IDLE -> POP high 1 cycle; next cycle EMPTY=0, MEM_RES_RM=0x1234, MEM_DEST_RM=5, MEM_WB_RM=1.
2. LB, addr 0x00000103, sign=1, ack next cycle with 0x80FFFF7F -> pushed 0xFFFFFF80; repeat with sign=0 -> 0x00000080; LH addr 0x102 sign=1 -> 0xFFFF80FF.
3. SH, addr 0x00000102, data 0x0000ABCD -> MCACHE_ADR=0x100, DATA=0xABCDABCD, SEL=1100, STORE=1; on ack pushed with wb=0, DEST forced irrelevant.
4. Ack delayed 3 cycles with a second entry waiting upstream -> MCACHE outputs stable all 3 cycles, POP=0, no push; second entry popped the cycle after return to IDLE.
5. MEM2WBK_POP_SW=0, three ALU entries -> first two pushed, third not popped (POP=0) while full; one writeback pop -> third popped/pushed the following cycle, order preserved.
6. Reset asserted during WAIT_ACK with ack arriving same and next cycle -> next cycle MCACHE_LOAD=0, EMPTY=1, POP=0; no entry pushed from the stale ack.
